// File: rtl/ex_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : ex_bus_bridge
//  Description : Registered bridge between the core data-access port and the
//                peripheral bus. A core request is captured into registers
//                and presented on the bus as a valid/ready transaction. The
//                core is stalled through core_hold_o until the slave responds
//                or a timeout ends the transaction. A timeout sets a sticky
//                error flag and records the offending address.
//
//  Ports       :
//    clk, rst       - clock, synchronous active-high reset
//    core_addr_i    - core access address (already muxed by the core)
//    core_data_i    - core write data
//    core_req_i     - core access request
//    core_we_i      - 1 = write, 0 = read
//    core_data_o    - read data to core (valid in DONE only, else 0)
//    core_hold_o    - stall request to the core pipeline
//    m_addr_o       - bus address        (captured register)
//    m_data_o       - bus write data     (captured register)
//    m_we_o         - bus write enable   (captured register)
//    m_valid_o      - bus request valid  (high for the whole REQ state)
//    m_ready_i      - slave accepts/completes the transaction
//    m_data_i       - slave read data, sampled with m_ready_i
//    err_o          - sticky timeout flag
//    err_addr_o     - address of the most recent timed-out transaction
//    err_clr_i      - clears err_o (a coincident timeout takes priority)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_bus_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_data_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    output logic [DATA_W-1:0] core_data_o,
    output logic              core_hold_o,

    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_we_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    input  logic [DATA_W-1:0] m_data_i,

    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o,
    input  logic              err_clr_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = 16;

    // Last counter value allowed in REQ; reaching it without m_ready_i ends
    // the transaction, so REQ lasts at most TIMEOUT cycles.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;

    // ------------------------------------------------------------------------
    // Control strobes from the next-state logic
    // ------------------------------------------------------------------------
    logic w_capture;    // latch the core request (IDLE with core_req_i)
    logic w_accept;     // slave responded in REQ
    logic w_timeout;    // REQ expired without a response
    logic w_cnt_inc;    // another wait state in REQ

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        w_cnt_inc    = 1'b0;
        core_hold_o  = 1'b0;
        m_valid_o    = 1'b0;
        core_data_o  = '0;

        case (r_state)
            ST_IDLE: begin
                // The stall must be raised in the same cycle the request is
                // seen, since the core would otherwise advance on this edge.
                core_hold_o = core_req_i;
                if (core_req_i) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_REQ;
                end
            end

            ST_REQ: begin
                core_hold_o = 1'b1;
                m_valid_o   = 1'b1;
                // The transaction runs to completion even if core_req_i
                // drops; a response in the expiry cycle beats the timeout.
                if (m_ready_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end

            ST_DONE: begin
                // Hold is released here so the core advances on this edge.
                // A core_req_i still high belongs to the finished access and
                // must not start a second transaction.
                core_data_o  = r_rdata;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: captured request, wait counter, read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_capture) begin
                r_addr  <= core_addr_i;
                r_wdata <= core_data_i;
                r_we    <= core_we_i;
                r_cnt   <= '0;
            end else if (w_cnt_inc) begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end

            // Writes and timeouts both return zero so the core never sees
            // stale read data from an earlier access.
            if (w_accept) begin
                r_rdata <= r_we ? '0 : m_data_i;
            end else if (w_timeout) begin
                r_rdata <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Error reporting: sticky flag, set takes priority over clear
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            if (w_timeout) begin
                r_err      <= 1'b1;
                r_err_addr <= r_addr;
            end else if (err_clr_i) begin
                r_err      <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign m_addr_o   = r_addr;
    assign m_data_o   = r_wdata;
    assign m_we_o     = r_we;
    assign err_o      = r_err;
    assign err_addr_o = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ex_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_bus_bridge
//  Description : Directed self-checking bench for ex_bus_bridge with
//                TIMEOUT = 8. Inputs change 1 time unit after the rising
//                edge; outputs are sampled at the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_bus_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] core_addr_i;
    logic [DATA_W-1:0] core_data_i;
    logic              core_req_i;
    logic              core_we_i;
    logic [DATA_W-1:0] core_data_o;
    logic              core_hold_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_we_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [DATA_W-1:0] m_data_i;
    logic              err_o;
    logic [ADDR_W-1:0] err_addr_o;
    logic              err_clr_i;

    int n_cmp;
    int n_bad;

    ex_bus_bridge #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_addr_i (core_addr_i),
        .core_data_i (core_data_i),
        .core_req_i  (core_req_i),
        .core_we_i   (core_we_i),
        .core_data_o (core_data_o),
        .core_hold_o (core_hold_o),
        .m_addr_o    (m_addr_o),
        .m_data_o    (m_data_o),
        .m_we_o      (m_we_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_i    (m_data_i),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .err_clr_i   (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the drive point of the next cycle.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Move to the sample point of the current cycle.
    task automatic to_sample();
        #4;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        to_drive();
        to_drive();
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b need 0", m_valid_o); end
        n_cmp++; if (m_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b need 0", m_we_o); end
        n_cmp++; if (m_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h need 0", m_addr_o); end
        n_cmp++; if (m_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_mdata: got %h need 0", m_data_o); end
        n_cmp++; if (core_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_cdata: got %h need 0", core_data_o); end
        n_cmp++; if (core_hold_o !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b need 0", core_hold_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b need 0", err_o); end
        n_cmp++; if (err_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_err_addr: got %h need 0", err_addr_o); end
        to_drive();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_read_min();
        // N: request seen in IDLE
        to_drive();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h1000_0004; core_data_i = 32'h0;
        to_sample();
        n_cmp++; if (core_hold_o !== 1'b1) begin n_bad++; $display("FAIL rd_hold_n: got %b need 1", core_hold_o); end
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_valid_n: got %b need 0", m_valid_o); end
        // N+1: REQ, slave ready immediately
        to_drive();
        m_ready_i = 1'b1; m_data_i = 32'hDEAD_BEEF;
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b1) begin n_bad++; $display("FAIL rd_valid_n1: got %b need 1", m_valid_o); end
        n_cmp++; if (core_hold_o !== 1'b1) begin n_bad++; $display("FAIL rd_hold_n1: got %b need 1", core_hold_o); end
        n_cmp++; if (m_addr_o !== 32'h1000_0004) begin n_bad++; $display("FAIL rd_addr: got %h need 10000004", m_addr_o); end
        n_cmp++; if (m_we_o !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b need 0", m_we_o); end
        n_cmp++; if (core_data_o !== 32'h0) begin n_bad++; $display("FAIL rd_cdata_req: got %h need 0", core_data_o); end
        // N+2: DONE
        to_drive();
        m_ready_i = 1'b0; m_data_i = 32'h0;
        to_sample();
        n_cmp++; if (core_hold_o !== 1'b0) begin n_bad++; $display("FAIL rd_hold_done: got %b need 0", core_hold_o); end
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_valid_done: got %b need 0", m_valid_o); end
        n_cmp++; if (core_data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_cdata_done: got %h need deadbeef", core_data_o); end
        // N+3: back in IDLE
        to_drive();
        core_req_i = 1'b0;
        to_sample();
        n_cmp++; if (core_data_o !== 32'h0) begin n_bad++; $display("FAIL rd_cdata_idle: got %h need 0", core_data_o); end
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_valid_idle: got %b need 0", m_valid_o); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_write_wait();
        int n_valid;
        int n_hold;
        n_valid = 0;
        n_hold  = 0;
        to_drive();
        core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h2000_0000; core_data_i = 32'h1234_5678;
        to_sample();
        if (core_hold_o === 1'b1) n_hold++;
        if (m_valid_o === 1'b1) n_valid++;
        for (int i = 0; i < 4; i++) begin
            to_drive();
            m_ready_i = (i == 3);
            m_data_i  = 32'hFFFF_FFFF;  // must be ignored on a write
            to_sample();
            if (core_hold_o === 1'b1) n_hold++;
            if (m_valid_o === 1'b1) n_valid++;
            n_cmp++; if (m_addr_o !== 32'h2000_0000) begin n_bad++; $display("FAIL wr_addr[%0d]: got %h need 20000000", i, m_addr_o); end
            n_cmp++; if (m_data_o !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_data[%0d]: got %h need 12345678", i, m_data_o); end
            n_cmp++; if (m_we_o !== 1'b1) begin n_bad++; $display("FAIL wr_we[%0d]: got %b need 1", i, m_we_o); end
        end
        // DONE
        to_drive();
        m_ready_i = 1'b0; m_data_i = 32'h0;
        to_sample();
        if (core_hold_o === 1'b1) n_hold++;
        if (m_valid_o === 1'b1) n_valid++;
        n_cmp++; if (core_data_o !== 32'h0) begin n_bad++; $display("FAIL wr_cdata_done: got %h need 0", core_data_o); end
        to_drive();
        core_req_i = 1'b0; core_we_i = 1'b0;
        to_sample();
        if (core_hold_o === 1'b1) n_hold++;
        if (m_valid_o === 1'b1) n_valid++;
        n_cmp++; if (n_valid !== 4) begin n_bad++; $display("FAIL wr_valid_cycles: got %0d need 4", n_valid); end
        n_cmp++; if (n_hold !== 5) begin n_bad++; $display("FAIL wr_hold_cycles: got %0d need 5", n_hold); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_timeout();
        int n_valid;
        n_valid = 0;
        to_drive();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h3000_0010;
        to_sample();
        for (int i = 0; i < TIMEOUT; i++) begin
            to_drive();
            m_ready_i = 1'b0;
            if (i == 1) core_req_i = 1'b0;  // dropping req must not abort
            to_sample();
            if (m_valid_o === 1'b1) n_valid++;
            n_cmp++; if (core_hold_o !== 1'b1) begin n_bad++; $display("FAIL to_hold[%0d]: got %b need 1", i, core_hold_o); end
        end
        n_cmp++; if (n_valid !== TIMEOUT) begin n_bad++; $display("FAIL to_valid_cycles: got %0d need %0d", n_valid, TIMEOUT); end
        // DONE
        to_drive();
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL to_valid_done: got %b need 0", m_valid_o); end
        n_cmp++; if (core_data_o !== 32'h0) begin n_bad++; $display("FAIL to_cdata_done: got %h need 0", core_data_o); end
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b need 1", err_o); end
        n_cmp++; if (err_addr_o !== 32'h3000_0010) begin n_bad++; $display("FAIL to_err_addr: got %h need 30000010", err_addr_o); end
        // Late response in IDLE
        to_drive();
        m_ready_i = 1'b1; m_data_i = 32'hAAAA_5555;
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL to_late_valid: got %b need 0", m_valid_o); end
        to_drive();
        m_ready_i = 1'b0; m_data_i = 32'h0;
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL to_late_valid2: got %b need 0", m_valid_o); end
        n_cmp++; if (core_data_o !== 32'h0) begin n_bad++; $display("FAIL to_late_cdata: got %h need 0", core_data_o); end
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky: got %b need 1", err_o); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int n_valid;
        n_valid = 0;
        // First access, address A
        to_drive();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h4000_0000;
        to_sample();
        if (m_valid_o === 1'b1) n_valid++;
        to_drive();
        m_ready_i = 1'b1; m_data_i = 32'h1111_1111;
        to_sample();
        if (m_valid_o === 1'b1) n_valid++;
        n_cmp++; if (m_addr_o !== 32'h4000_0000) begin n_bad++; $display("FAIL b2b_addr_a: got %h need 40000000", m_addr_o); end
        // DONE with req still high and address still A
        to_drive();
        m_ready_i = 1'b0; m_data_i = 32'h0;
        to_sample();
        if (m_valid_o === 1'b1) n_valid++;
        n_cmp++; if (core_data_o !== 32'h1111_1111) begin n_bad++; $display("FAIL b2b_cdata_a: got %h need 11111111", core_data_o); end
        n_cmp++; if (core_hold_o !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_done_a: got %b need 0", core_hold_o); end
        // Core advanced; second access, address B, req kept high
        to_drive();
        core_addr_i = 32'h4000_0008;
        to_sample();
        if (m_valid_o === 1'b1) n_valid++;
        n_cmp++; if (core_hold_o !== 1'b1) begin n_bad++; $display("FAIL b2b_hold_idle_b: got %b need 1", core_hold_o); end
        to_drive();
        m_ready_i = 1'b1; m_data_i = 32'h2222_2222;
        to_sample();
        if (m_valid_o === 1'b1) n_valid++;
        n_cmp++; if (m_addr_o !== 32'h4000_0008) begin n_bad++; $display("FAIL b2b_addr_b: got %h need 40000008", m_addr_o); end
        to_drive();
        m_ready_i = 1'b0; m_data_i = 32'h0;
        to_sample();
        if (m_valid_o === 1'b1) n_valid++;
        n_cmp++; if (core_data_o !== 32'h2222_2222) begin n_bad++; $display("FAIL b2b_cdata_b: got %h need 22222222", core_data_o); end
        for (int i = 0; i < 3; i++) begin
            to_drive();
            core_req_i = 1'b0;
            to_sample();
            if (m_valid_o === 1'b1) n_valid++;
        end
        n_cmp++; if (n_valid !== 2) begin n_bad++; $display("FAIL b2b_valid_cycles: got %0d need 2", n_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        to_drive();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h5000_0000;
        to_sample();
        to_drive();
        m_ready_i = 1'b0;
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b1) begin n_bad++; $display("FAIL rm_valid_req1: got %b need 1", m_valid_o); end
        // Second REQ cycle: reset asserted
        to_drive();
        rst = 1'b1; core_req_i = 1'b0;
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b1) begin n_bad++; $display("FAIL rm_valid_req2: got %b need 1", m_valid_o); end
        to_drive();
        rst = 1'b0;
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL rm_valid_after: got %b need 0", m_valid_o); end
        n_cmp++; if (core_hold_o !== 1'b0) begin n_bad++; $display("FAIL rm_hold_after: got %b need 0", core_hold_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rm_err_after: got %b need 0", err_o); end
        to_drive();
        to_sample();
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL rm_valid_idle: got %b need 0", m_valid_o); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_ready_at_timeout();
        to_drive();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h8000_0000;
        to_sample();
        for (int i = 0; i < TIMEOUT; i++) begin
            to_drive();
            m_ready_i = (i == TIMEOUT - 1);
            m_data_i  = 32'h5A5A_5A5A;
            to_sample();
        end
        to_drive();
        m_ready_i = 1'b0; m_data_i = 32'h0;
        to_sample();
        n_cmp++; if (core_data_o !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL rt_cdata: got %h need 5a5a5a5a", core_data_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rt_err: got %b need 0", err_o); end
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL rt_valid_done: got %b need 0", m_valid_o); end
        to_drive();
        core_req_i = 1'b0;
        to_sample();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_err_clr();
        // First timeout at 0x6000_0000
        to_drive();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h6000_0000;
        to_sample();
        for (int i = 0; i < TIMEOUT; i++) begin
            to_drive();
            to_sample();
        end
        to_drive();
        core_req_i = 1'b0;
        to_sample();
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL ec_err_first: got %b need 1", err_o); end
        n_cmp++; if (err_addr_o !== 32'h6000_0000) begin n_bad++; $display("FAIL ec_addr_first: got %h need 60000000", err_addr_o); end
        // Second timeout at 0x7000_0004, clear pulsed in the expiry cycle
        to_drive();
        core_req_i = 1'b1; core_addr_i = 32'h7000_0004;
        to_sample();
        for (int i = 0; i < TIMEOUT; i++) begin
            to_drive();
            err_clr_i = (i == TIMEOUT - 1);
            to_sample();
        end
        to_drive();
        err_clr_i = 1'b1; core_req_i = 1'b0;
        to_sample();
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL ec_err_set_wins: got %b need 1", err_o); end
        n_cmp++; if (err_addr_o !== 32'h7000_0004) begin n_bad++; $display("FAIL ec_addr_second: got %h need 70000004", err_addr_o); end
        // Clear alone takes effect on this edge
        to_drive();
        err_clr_i = 1'b0;
        to_sample();
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL ec_err_cleared: got %b need 0", err_o); end
        n_cmp++; if (err_addr_o !== 32'h7000_0004) begin n_bad++; $display("FAIL ec_addr_held: got %h need 70000004", err_addr_o); end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        core_addr_i = '0;
        core_data_i = '0;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        m_ready_i   = 1'b0;
        m_data_i    = '0;
        err_clr_i   = 1'b0;

        test_reset();
        test_read_min();
        test_write_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_ready_at_timeout();
        test_err_clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_bus_bridge.md
# ex_bus_bridge

Registered bus bridge between the core's data-access port and the peripheral bus. It turns the core's combinational request/response into a valid/ready transaction with wait states. The core is stalled through the hold flag until the transaction completes; the core consumes that flag on its bus-hold input. A stuck slave cannot hang the core: a timeout ends the transaction and records an error.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles spent in REQ waiting for m_ready_i (1..65535)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- core_addr_i  in  ADDR_W  core access address (write or read address, already muxed by core)
- core_data_i  in  DATA_W  core write data
- core_req_i  in  1  core access request
- core_we_i  in  1  1 = write, 0 = read
- core_data_o  out  DATA_W  read data returned to core
- core_hold_o  out  1  stall request to core pipeline
- m_addr_o  out  ADDR_W  bus address
- m_data_o  out  DATA_W  bus write data
- m_we_o  out  1  bus write enable
- m_valid_o  out  1  bus request valid
- m_ready_i  in  1  slave accepts/completes the transaction this cycle
- m_data_i  in  DATA_W  slave read data, sampled when m_ready_i=1
- err_o  out  1  sticky timeout flag
- err_addr_o  out  ADDR_W  address of the most recent timed-out transaction
- err_clr_i  in  1  clears err_o

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - core_req_i=1 → capture core_addr_i, core_data_i and core_we_i into registers, clear the timeout counter, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - m_valid_o=1; m_addr_o, m_data_o and m_we_o come from the captured registers.
  - m_ready_i=1 → on a read, latch m_data_i into the rdata register; on a write, load rdata with 0. Go to DONE.
  - Otherwise the counter increments.
  - Counter = TIMEOUT-1 with m_ready_i=0 → rdata=0, err_o set, err_addr_o = captured address, go to DONE.
  - m_ready_i=1 and the timeout in the same cycle → ready wins; no error is recorded.
- DONE:
  - core_data_o = rdata register.
  - Always return to IDLE the next cycle.
  - A core_req_i still high in DONE belongs to the completed access and is ignored.
- core_hold_o = core_req_i & (state==IDLE) | (state==REQ). It is 0 in DONE.
- core_data_o = 0 in IDLE and REQ.
- In REQ, core_req_i dropping does not abort the transaction; it runs to completion.
- m_ready_i is ignored outside REQ. A late slave response after a timeout is discarded.
- err_clr_i clears err_o. If err_clr_i=1 coincides with a new timeout, set wins. err_addr_o holds its value until the next timeout.
- Counter is 16 bits. Values at or above TIMEOUT are unreachable.

## Timing
- Reset values:
  - state IDLE
  - m_valid_o=0, m_we_o=0
  - m_addr_o=0, m_data_o=0
  - core_data_o=0, core_hold_o=0 (with core_req_i=0)
  - err_o=0, err_addr_o=0
  - counter=0, rdata=0
- Minimum latency, ready on first REQ cycle:
  - req seen in cycle N; hold=1 in N and N+1.
  - m_valid_o=1 in N+1.
  - DONE in N+2: hold=0, data valid; the core advances on the N+2 edge.
- Each wait state adds one cycle of hold.
- Back-to-back accesses: a new request can be seen in IDLE at N+3. Throughput is one access per 3 cycles minimum.
- Timeout path: TIMEOUT cycles of m_valid_o=1, then DONE. err_o is visible from DONE onward.
- Reset mid-transaction: on the rst edge the state goes to IDLE and m_valid_o drops next cycle. The transaction is abandoned and the slave must tolerate it.
- m_* outputs are registered and stable for the whole of REQ.

## Test plan
- Read at 0x1000_0004, m_ready_i=1 on the first REQ cycle, m_data_i=0xDEADBEEF → hold high 2 cycles; core_data_o=0xDEADBEEF in DONE; m_valid_o high exactly 1 cycle.
- Write 0x12345678 to 0x2000_0000 with 3 wait states → m_valid_o high 4 cycles with stable addr/data and m_we_o=1; hold high 5 cycles; core_data_o=0 in DONE.
- Read at 0x3000_0010, m_ready_i never asserted, TIMEOUT=8 → m_valid_o high 8 cycles, then DONE with core_data_o=0, err_o=1, err_addr_o=0x3000_0010. A late m_ready_i pulse in IDLE has no effect.
- Two consecutive reads with core_req_i held high → exactly two bus transactions, each with its own captured address; no duplicate transaction issued from DONE.
- rst asserted in the 2nd REQ cycle → next cycle m_valid_o=0, core_hold_o=0 (req low), err_o=0.
- err_o set, then err_clr_i=1 in the same cycle as a second timeout → err_o stays 1 and err_addr_o updates. A following err_clr_i alone → err_o=0.
